// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: takes a 16-bit word-count header
// and then the data bytes, packs them little-endian and writes one word per WRITE cycle.
module imem_loader #(
  parameter int unsigned DEPTH      = 64,
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        WR_EN,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_DATA,
  output logic        CPU_STALL,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] WORD_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic        xfer;
  logic [15:0] hdr_n;
  logic [15:0] hdr_full;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [15:0] word_idx_inc;
  logic [23:0] lanes;
  logic [15:0] word_cnt_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;

  assign xfer         = BYTE_VALID && BYTE_READY;
  assign hdr_full     = {BYTE_IN, hdr_n[7:0]};
  assign word_idx_inc = word_idx + 16'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) state_nxt = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (xfer) begin
          if (hdr_full == 16'd0)         state_nxt = S_DONE;
          else if (hdr_full > DEPTH_W)   state_nxt = S_ERR;
          else                           state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = (word_idx_inc == hdr_n) ? S_DONE : S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BYTE_READY = 1'b0;
    CPU_STALL  = 1'b0;
    DONE       = 1'b0;
    ERR        = 1'b0;
    case (state)
      S_HDR_LO, S_HDR_HI, S_DATA: begin
        BYTE_READY = 1'b1;
        CPU_STALL  = 1'b1;
      end
      S_WRITE: CPU_STALL = 1'b1;
      S_DONE:  DONE      = 1'b1;
      S_ERR:   ERR       = 1'b1;
      default: ;
    endcase
  end

  // Write strobe, address and data are captured on the 4th byte's transfer so
  // they appear registered during the single WRITE cycle and are zero otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hdr_n      <= '0;
      byte_idx   <= '0;
      word_idx   <= '0;
      lanes      <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            word_cnt_q <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            lanes      <= '0;
          end
        end
        S_HDR_LO: begin
          if (xfer) hdr_n[7:0] <= BYTE_IN;
        end
        S_HDR_HI: begin
          if (xfer) begin
            hdr_n[15:8] <= BYTE_IN;
            byte_idx    <= '0;
            word_idx    <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: lanes[7:0]   <= BYTE_IN;
              2'd1: lanes[15:8]  <= BYTE_IN;
              2'd2: lanes[23:16] <= BYTE_IN;
              default: begin
                wr_en_q   <= 1'b1;
                wr_data_q <= {BYTE_IN, lanes};
                wr_addr_q <= START_ADDR + {14'd0, word_idx, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: begin
          word_idx   <= word_idx_inc;
          word_cnt_q <= word_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign WR_EN    = wr_en_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-by-cycle vector table plus hand-written
// full-depth load and asynchronous mid-load reset sequences.
module tb_imem_loader;

  localparam int unsigned DEPTH      = 64;
  localparam logic [31:0] START_ADDR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        WR_EN;
  logic [31:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic        CPU_STALL;
  logic        DONE;
  logic        ERR;
  logic [15:0] WORD_CNT;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  imem_loader #(.DEPTH(DEPTH), .START_ADDR(START_ADDR)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CPU_STALL(CPU_STALL),
    .DONE(DONE), .ERR(ERR), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        wr;
    logic        stall;
    logic        done;
    logic        err;
    logic [15:0] cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];

  // Non-write cycle: outputs expected for the current state, inputs for this cycle.
  function automatic vec_t rx(input logic s, input logic v, input logic [7:0] b,
                              input logic rdy, input logic stl, input logic dn,
                              input logic er, input logic [15:0] c);
    vec_t r;
    r.start = s; r.valid = v; r.data = b;
    r.ready = rdy; r.wr = 1'b0; r.stall = stl; r.done = dn; r.err = er;
    r.cnt = c; r.addr = '0; r.wdata = '0;
    return r;
  endfunction

  // WRITE cycle: strobe high, not ready, stalled.
  function automatic vec_t wv(input logic v, input logic [7:0] b, input logic [31:0] a,
                              input logic [31:0] d, input logic [15:0] c);
    vec_t r;
    r.start = 1'b0; r.valid = v; r.data = b;
    r.ready = 1'b0; r.wr = 1'b1; r.stall = 1'b1; r.done = 1'b0; r.err = 1'b0;
    r.cnt = c; r.addr = a; r.wdata = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return 96'({BYTE_READY, WR_EN, CPU_STALL, DONE, ERR, WORD_CNT, WR_ADDR, WR_DATA});
  endfunction

  task automatic drive(input logic s, input logic v, input logic [7:0] b);
    START = s; BYTE_VALID = v; BYTE_IN = b;
    @(posedge CLK); @(negedge CLK);
    START = 1'b0; BYTE_VALID = 1'b0;
  endtask

  // Full load with continuous valid; byte k of word w is base + 4*w + k.
  task automatic run_load(input logic [15:0] n, input logic [7:0] base);
    int unsigned total, bi, writes, cyc;
    logic        xfer;
    logic [31:0] last_addr, exp_w, exp_last;
    total = 2 + 4 * int'(n);
    START = 1'b1; BYTE_VALID = 1'b0;
    @(posedge CLK); @(negedge CLK);
    START = 1'b0;
    bi = 0; writes = 0; cyc = 0; last_addr = '0;
    while (!DONE && !ERR && cyc < 4000) begin
      if (WR_EN) begin
        exp_w = {base + 8'(4*writes+3), base + 8'(4*writes+2),
                 base + 8'(4*writes+1), base + 8'(4*writes)};
        check($sformatf("load_wr%0d", writes), 96'({WR_ADDR, WR_DATA}),
              96'({START_ADDR + 32'(4*writes), exp_w}));
        last_addr = WR_ADDR;
        writes++;
      end
      if (bi < total) begin
        BYTE_VALID = 1'b1;
        BYTE_IN = (bi == 0) ? n[7:0] : (bi == 1) ? n[15:8] : base + 8'(bi - 2);
      end else begin
        BYTE_VALID = 1'b0;
      end
      xfer = BYTE_VALID && BYTE_READY;
      @(posedge CLK); @(negedge CLK);
      if (xfer) bi++;
      cyc++;
    end
    BYTE_VALID = 1'b0;
    check("load_end", 96'({DONE, ERR, CPU_STALL, BYTE_READY, WORD_CNT, 16'(writes)}),
          96'({1'b1, 1'b0, 1'b0, 1'b0, n, n}));
    exp_last = (n == 16'd0) ? START_ADDR : START_ADDR + 32'(4 * (int'(n) - 1));
    check("load_last_addr", 96'(last_addr), 96'(exp_last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; START = 1'b0; BYTE_VALID = 1'b0; BYTE_IN = '0;

    // Main stream: 02 00 | 13 00 10 00 | 93 00 20 00
    vecs.push_back(rx(0, 0, 8'h00, 0, 0, 0, 0, 16'd0));
    vecs.push_back(rx(1, 0, 8'h00, 0, 0, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h02, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h13, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h10, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(wv(0, 8'h00, 32'h0, 32'h0010_0013, 16'd0));
    vecs.push_back(rx(0, 1, 8'h93, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 1, 8'h20, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd1));
    vecs.push_back(wv(0, 8'h00, 32'h4, 32'h0020_0093, 16'd1));
    vecs.push_back(rx(0, 1, 8'h55, 0, 0, 1, 0, 16'd2));
    // Same stream with valid toggling and a byte offered during WRITE
    vecs.push_back(rx(1, 0, 8'h00, 0, 0, 1, 0, 16'd2));
    vecs.push_back(rx(0, 1, 8'h02, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h13, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h10, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(wv(1, 8'h93, 32'h0, 32'h0010_0013, 16'd0));
    vecs.push_back(rx(0, 1, 8'h93, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 1, 8'h20, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 0, 8'hee, 1, 1, 0, 0, 16'd1));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd1));
    vecs.push_back(wv(0, 8'h00, 32'h4, 32'h0020_0093, 16'd1));
    vecs.push_back(rx(0, 0, 8'h00, 0, 0, 1, 0, 16'd2));
    // Header 00 00: straight to DONE, no writes
    vecs.push_back(rx(1, 0, 8'h00, 0, 0, 1, 0, 16'd2));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'hff, 0, 0, 1, 0, 16'd0));
    // Header 41 00 (DEPTH+1): ERR, no writes, not ready
    vecs.push_back(rx(1, 0, 8'h00, 0, 0, 1, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h41, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h00, 1, 1, 0, 0, 16'd0));
    vecs.push_back(rx(0, 1, 8'h12, 0, 0, 0, 1, 16'd0));
    vecs.push_back(rx(0, 0, 8'h00, 0, 0, 0, 1, 16'd0));

    repeat (2) @(negedge CLK);
    check("in_reset", outs(), 96'd0);
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      check($sformatf("vec%0d", i), outs(),
            96'({vecs[i].ready, vecs[i].wr, vecs[i].stall, vecs[i].done, vecs[i].err,
                 vecs[i].cnt, vecs[i].addr, vecs[i].wdata}));
      START = vecs[i].start; BYTE_VALID = vecs[i].valid; BYTE_IN = vecs[i].data;
      @(posedge CLK); @(negedge CLK);
    end
    START = 1'b0; BYTE_VALID = 1'b0;

    // N == DEPTH restarted from ERR: 64 writes, last at 0xFC
    run_load(16'd64, 8'h00);

    // Asynchronous reset after two data bytes of a one-word load
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h01);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'haa);
    drive(0, 1, 8'hbb);
    check("pre_rst_stall", 96'({CPU_STALL, BYTE_READY}), 96'(2'b11));
    #2 RST_N = 1'b0;
    #1 check("rst_async", outs(), 96'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    check("post_rst", outs(), 96'd0);
    run_load(16'd1, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory, which is read-only and addressed by PC.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or debug port.
- Packs the bytes little-endian into 32-bit instructions and issues single-cycle word writes at sequential byte addresses.
- Holds the core in stall for the whole load, so the memory can be reprogrammed without editing the hard-coded contents.

Parameters:
- DEPTH, 64: instruction memory capacity in 32-bit words; the maximum legal word count.
- START_ADDR, 32'h0000_0000: byte address of the first written word; must be word aligned.

Ports:
- CLK  in  1  single system clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  level sampled each cycle; begins a load when high in IDLE, DONE or ERR.
- BYTE_IN  in  8  stream byte.
- BYTE_VALID  in  1  BYTE_IN is valid this cycle.
- BYTE_READY  out  1  loader accepts a byte this cycle; a transfer occurs when BYTE_VALID and BYTE_READY are both high.
- WR_EN  out  1  one-cycle write strobe to the instruction memory.
- WR_ADDR  out  32  byte address of the write; the memory indexes it as WR_ADDR>>2.
- WR_DATA  out  32  instruction word to write.
- CPU_STALL  out  1  high while a load is in progress; the core must freeze PC.
- DONE  out  1  sticky; the load completed successfully.
- ERR  out  1  sticky; the header word count exceeded DEPTH.
- WORD_CNT  out  16  number of words written in the current or last load.

Behaviour:
- Reset (asynchronous, RST_N low):
  - State returns to IDLE.
  - All outputs go to 0 and the internal byte/word counters clear.
  - A partial word is discarded, and no WR_EN is issued after reset.
- Stream format: a 2-byte header N (low byte first), followed by 4*N data bytes. Each word is assembled byte0 = [7:0] through byte3 = [31:24].
- States:
  - IDLE: BYTE_READY=0, CPU_STALL=0. START=1 moves to HDR_LO and clears DONE, ERR and WORD_CNT.
  - HDR_LO: BYTE_READY=1, CPU_STALL=1. On a transfer, latch N[7:0] and move to HDR_HI.
  - HDR_HI: BYTE_READY=1. On a transfer, latch N[15:8], then:
    - if N==0, go to DONE;
    - if N>DEPTH, go to ERR;
    - otherwise go to DATA with byte index 0 and word index 0.
  - DATA: BYTE_READY=1. Each transfer shifts the byte into lane[byte index] and increments the byte index (2 bits). The transfer that fills lane 3 moves to WRITE.
  - WRITE: exactly one cycle, with BYTE_READY=0.
    - WR_EN=1, WR_DATA = assembled word, WR_ADDR = START_ADDR + 4*word index.
    - Increment word index and WORD_CNT.
    - If word index+1==N go to DONE, else return to DATA.
  - DONE: DONE=1, CPU_STALL=0, BYTE_READY=0. START restarts the load.
  - ERR: ERR=1, CPU_STALL=0, BYTE_READY=0, and no writes occur. START restarts the load.
- Output timing and stall:
  - WR_EN, WR_ADDR and WR_DATA are registered. They are valid in the cycle after the 4th byte's transfer and are 0 at all other times.
  - CPU_STALL goes high the cycle after START is sampled. It stays high through the final WRITE cycle and falls on entry to DONE or ERR.
- Handshake and control rules:
  - BYTE_VALID with BYTE_READY=0 is not a transfer; the source must hold the byte.
  - Gaps in BYTE_VALID are allowed in any receiving state, and the state holds.
  - START is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- Arithmetic: the word index is 16 bits, and address arithmetic is 32-bit with wrap ignored (N≤DEPTH ensures no overflow).
- Boundaries:
  - N==DEPTH is legal.
  - N==DEPTH+1 is ERR.
  - A byte presented in the WRITE cycle is stalled, not dropped.

Test Plan:
- Reset with BYTE_VALID=0 -> all outputs 0, state IDLE, BYTE_READY=0.
- START, then bytes 02 00 | 13 00 10 00 | 93 00 20 00 -> writes 32'h00100013 at address 0x0 and 32'h00200093 at address 0x4. Each WR_EN lasts 1 cycle, the cycle after the 4th byte. Ends with DONE=1, WORD_CNT=2, CPU_STALL falling after the last write.
- Same stream with BYTE_VALID toggling 1/0 every cycle and a byte offered during WRITE -> identical writes, no byte lost or duplicated.
- Header 41 00 with DEPTH=64 -> ERR=1, no WR_EN, BYTE_READY=0. A following START with header 40 00 plus 256 bytes -> 64 writes, last at WR_ADDR=0xFC, DONE=1.
- Header 00 00 -> DONE=1 immediately, WORD_CNT=0, no writes.
- RST_N asserted after 2 data bytes -> outputs 0 immediately. A new load then starts at WR_ADDR=START_ADDR with no stale bytes in WR_DATA.
